// File: rtl/mem_arbiter_pkg.sv
// Shared types for the unified-memory arbiter: FSM state encoding and the
// registered memory-request bundle.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_BUSY = 2'd1,
        D_BUSY = 2'd2,
        RESP   = 2'd3
    } arb_state_t;

    typedef struct packed {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_req_t;

    localparam logic [3:0] BE_WORD = 4'hF;

    // Instruction fetches are always full-word reads.
    function automatic mem_req_t fetch_req(input logic [31:0] addr);
        mem_req_t r;
        r.we    = 1'b0;
        r.be    = BE_WORD;
        r.addr  = addr;
        r.wdata = '0;
        return r;
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Serialises fetch and load/store onto one variable-latency memory port,
// returns one-cycle valid pulses and drives the core stall.
//
// state  | meaning
// IDLE   | no transaction; arbitrate requests seen this cycle
// I_BUSY | fetch request on the memory port, waiting for m_ack
// D_BUSY | load/store request on the memory port, waiting for m_ack
// RESP   | one-cycle response to the owner; no arbitration
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int MAX_D_STREAK = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        if_kill,
    output logic [31:0] if_rdata,
    output logic        if_valid,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [3:0]  d_be,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_valid,
    output logic        m_req,
    output logic        m_we,
    output logic [3:0]  m_be,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic        m_ack,
    input  logic [31:0] m_rdata,
    output logic        stall
);

    localparam int SW = $clog2(MAX_D_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

    arb_state_t     state_q, state_d;
    mem_req_t       req_q;
    logic           grant_i, grant_d, ack_i, ack_d;
    logic           owner_d_q, kill_pend_q, fetch_owns;
    logic [SW-1:0]  d_streak_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        grant_i = 1'b0;
        grant_d = 1'b0;
        ack_i   = 1'b0;
        ack_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                // Data wins ties until it has used up its streak while fetch waits.
                if (d_req && !(if_req && d_streak_q == STREAK_MAX)) begin
                    grant_d = 1'b1;
                    state_d = D_BUSY;
                end else if (if_req) begin
                    grant_i = 1'b1;
                    state_d = I_BUSY;
                end
            end
            I_BUSY: begin
                ack_i = m_ack;
                if (m_ack) state_d = RESP;
            end
            D_BUSY: begin
                ack_d = m_ack;
                if (m_ack) state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign fetch_owns = (state_q == I_BUSY) || (state_q == RESP && !owner_d_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q       <= '0;
            m_req       <= 1'b0;
            owner_d_q   <= 1'b0;
            kill_pend_q <= 1'b0;
            d_streak_q  <= '0;
            if_rdata    <= '0;
            d_rdata     <= '0;
            if_valid    <= 1'b0;
            d_valid     <= 1'b0;
        end else begin
            if_valid <= 1'b0;
            d_valid  <= 1'b0;

            if (grant_d) begin
                req_q     <= '{we: d_we, be: d_be, addr: d_addr, wdata: d_wdata};
                m_req     <= 1'b1;
                owner_d_q <= 1'b1;
            end else if (grant_i) begin
                req_q     <= fetch_req(if_addr);
                m_req     <= 1'b1;
                owner_d_q <= 1'b0;
            end

            if (ack_i) begin
                m_req    <= 1'b0;
                if_rdata <= m_rdata;
                // A flush landing in the ack cycle still drops the response.
                if_valid <= !(kill_pend_q || if_kill);
            end
            if (ack_d) begin
                m_req   <= 1'b0;
                d_rdata <= m_rdata;
                d_valid <= 1'b1;
            end

            if (state_d == IDLE)
                kill_pend_q <= 1'b0;
            else if (if_kill && fetch_owns)
                kill_pend_q <= 1'b1;

            if (grant_i)
                d_streak_q <= '0;
            else if (grant_d && if_req && d_streak_q != STREAK_MAX)
                d_streak_q <= d_streak_q + SW'(1);
        end
    end

    assign m_we    = req_q.we;
    assign m_be    = req_q.be;
    assign m_addr  = req_q.addr;
    assign m_wdata = req_q.wdata;

    assign stall = (if_req && !if_valid) || (d_req && !d_valid);

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised bench for mem_arbiter: bench-side requesters and memory, with a
// transaction-timeline model predicting grants, port fields, valids and stall.
module tb_mem_arbiter;

    localparam int MAX_D = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req, if_kill, if_valid;
    logic [31:0] if_addr, if_rdata;
    logic        d_req, d_we, d_valid;
    logic [3:0]  d_be;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic        m_req, m_we, m_ack, stall;
    logic [3:0]  m_be;
    logic [31:0] m_addr, m_wdata, m_rdata;

    mem_arbiter #(.MAX_D_STREAK(MAX_D)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill),
        .if_rdata(if_rdata), .if_valid(if_valid),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_rdata(d_rdata), .d_valid(d_valid),
        .m_req(m_req), .m_we(m_we), .m_be(m_be), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_ack(m_ack), .m_rdata(m_rdata), .stall(stall)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Transaction timeline: grant decided in cycle g_cyc, memory port busy
    // g_cyc+1..ack_cyc, response in ack_cyc+1, arbiter free at ack_cyc+2.
    int          cyc = 0;
    bit          busy, own_d, killed;
    int          g_cyc, ack_cyc, free_cyc, streak;
    logic        e_we;
    logic [3:0]  e_be;
    logic [31:0] e_addr, e_wdata, e_rdata;

    bit          i_act, d_act;
    logic [31:0] i_addr_m, d_addr_m, d_wdata_m;
    logic        d_we_m;
    logic [3:0]  d_be_m;

    int p_if, p_d, p_kill, max_wait;

    task automatic model_reset();
        busy = 0; killed = 0; streak = 0; ack_cyc = -1; g_cyc = -1;
        i_act = 0; d_act = 0;
    endtask

    task automatic drive_cycle();
        int w;
        if (!i_act && $urandom_range(99) < p_if) begin
            i_act    = 1;
            i_addr_m = 32'h8000_0000 | ($urandom & 32'h0FFF_FFFC);
        end
        if (!d_act && $urandom_range(99) < p_d) begin
            d_act     = 1;
            d_addr_m  = 32'h9000_0000 | ($urandom & 32'h0FFF_FFFC);
            d_we_m    = 1'($urandom_range(1));
            d_be_m    = 4'($urandom_range(15, 1));
            d_wdata_m = $urandom;
        end

        m_ack   = busy && cyc == ack_cyc;
        m_rdata = $urandom;
        if (m_ack) e_rdata = m_rdata;

        if_kill = 1'b0;
        if (busy && $urandom_range(99) < p_kill) begin
            if (!own_d && cyc > g_cyc && cyc <= ack_cyc) begin
                if_kill = 1'b1;
                killed  = 1;
            end else if (own_d) begin
                if_kill = 1'b1;   // fetch does not own memory: must be ignored
            end
        end

        if_req  = i_act;
        if_addr = i_addr_m;
        d_req   = d_act;
        d_we    = d_we_m;
        d_be    = d_be_m;
        d_addr  = d_addr_m;
        d_wdata = d_wdata_m;

        if (!busy && cyc == free_cyc) begin
            if (d_act || i_act) begin
                own_d = d_act && !(i_act && streak == MAX_D);
                if (own_d) begin
                    e_we = d_we_m; e_be = d_be_m; e_addr = d_addr_m; e_wdata = d_wdata_m;
                    if (i_act) streak = (streak < MAX_D) ? streak + 1 : MAX_D;
                end else begin
                    e_we = 1'b0; e_be = 4'hF; e_addr = i_addr_m; e_wdata = '0;
                    streak = 0;
                end
                busy     = 1;
                killed   = 0;
                g_cyc    = cyc;
                w        = $urandom_range(max_wait);
                ack_cyc  = cyc + 1 + w;
                free_cyc = ack_cyc + 2;
            end else begin
                free_cyc = cyc + 1;
            end
        end
    endtask

    task automatic check_cycle();
        bit em, eiv, edv;
        em  = busy && cyc > g_cyc && cyc <= ack_cyc;
        eiv = busy && !own_d && !killed && cyc == ack_cyc + 1;
        edv = busy && own_d && cyc == ack_cyc + 1;
        check_val("m_req", m_req, em);
        check_val("if_valid", if_valid, eiv);
        check_val("d_valid", d_valid, edv);
        check_val("stall", stall, (i_act && !eiv) || (d_act && !edv));
        if (em) begin
            check_val("m_addr", m_addr, e_addr);
            check_val("m_we", m_we, e_we);
            check_val("m_be", m_be, e_be);
            if (own_d) check_val("m_wdata", m_wdata, e_wdata);
        end
        if (eiv) check_val("if_rdata", if_rdata, e_rdata);
        if (edv && !e_we) check_val("d_rdata", d_rdata, e_rdata);
        if (busy && cyc == ack_cyc + 1) begin
            if (own_d) d_act = 0;
            else       i_act = 0;
            busy = 0;
        end
    endtask

    task automatic run_phase(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            cyc++;
            drive_cycle();
            @(negedge clk);
            check_cycle();
        end
    endtask

    initial begin
        bit found;
        rst_n = 1'b0;
        if_req = 0; if_addr = '0; if_kill = 0;
        d_req = 0; d_we = 0; d_be = '0; d_addr = '0; d_wdata = '0;
        m_ack = 0; m_rdata = '0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_m_req", m_req, 0);
        check_val("rst_if_valid", if_valid, 0);
        check_val("rst_d_valid", d_valid, 0);
        check_val("rst_m_addr", m_addr, 0);
        check_val("rst_if_rdata", if_rdata, 0);
        check_val("rst_stall", stall, 0);
        rst_n = 1'b1;

        // Minimum-latency fetch
        @(posedge clk); #1; if_req = 1; if_addr = 32'h8000_0000;
        @(negedge clk);
        check_val("min_c0_m_req", m_req, 0);
        check_val("min_c0_stall", stall, 1);
        @(posedge clk); #1; m_ack = 1; m_rdata = 32'h0000_0013;
        @(negedge clk);
        check_val("min_c1_m_req", m_req, 1);
        check_val("min_c1_m_addr", m_addr, 32'h8000_0000);
        check_val("min_c1_m_we", m_we, 0);
        check_val("min_c1_m_be", m_be, 4'hF);
        @(posedge clk); #1; m_ack = 0;
        @(negedge clk);
        check_val("min_c2_if_valid", if_valid, 1);
        check_val("min_c2_if_rdata", if_rdata, 32'h0000_0013);
        check_val("min_c2_stall", stall, 0);
        @(posedge clk); #1; if_req = 0;
        @(negedge clk);
        check_val("min_c3_if_valid", if_valid, 0);
        check_val("min_c3_m_req", m_req, 0);
        check_val("min_c3_stall", stall, 0);

        model_reset();
        free_cyc = cyc + 1;
        p_if = 60;  p_d = 60;  p_kill = 0;  max_wait = 2; run_phase(300);
        p_if = 100; p_d = 100; p_kill = 0;  max_wait = 0; run_phase(200);
        p_if = 80;  p_d = 30;  p_kill = 30; max_wait = 3; run_phase(300);
        p_if = 50;  p_d = 50;  p_kill = 10; max_wait = 6; run_phase(300);

        // Reset in the middle of a data transaction
        p_if = 0; p_d = 100; p_kill = 0; max_wait = 6;
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            run_phase(1);
            if (busy && own_d && cyc > g_cyc && cyc < ack_cyc) found = 1;
        end
        if (!found) check_val("rst_find_d_busy", 0, 1);
        else begin
            rst_n = 1'b0;
            #1;
            check_val("mid_rst_m_req", m_req, 0);
            check_val("mid_rst_d_valid", d_valid, 0);
            check_val("mid_rst_if_valid", if_valid, 0);
            d_req = 0; if_req = 0; m_ack = 0; if_kill = 0;
            @(posedge clk);
            @(negedge clk);
            check_val("mid_rst_hold_m_req", m_req, 0);
            rst_n = 1'b1;
            model_reset();
            free_cyc = cyc + 1;
            p_if = 60; p_d = 60; p_kill = 10; max_wait = 2;
            run_phase(200);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
